// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
//
// Purpose : Shared types, constants and helpers for the two-digit BCD
//           counter (bcd_count2) and its decade cell (bcd_digit).
//
// Contents:
//   bcd_digit_t  - one BCD nibble, legal values 0..9
//   bcd_pair_t   - packed tens/ones byte as presented to the 7-seg stage
//   BCD_MAX      - largest legal digit (9)
//   BCD_MIN      - smallest legal digit (0)
//   bcd_valid()  - 1 when a nibble holds a legal decimal digit
// ---------------------------------------------------------------------------
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    // The tens digit sits in the upper nibble so the byte can be handed
    // straight to the dual 7-segment decoder without any reshuffling.
    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t ones;
    } bcd_pair_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // Nibbles 10..15 have no decimal meaning; a load carrying one of them
    // must be refused rather than corrupting the displayed count.
    function automatic logic bcd_valid(input bcd_digit_t digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit
//
// Purpose : One decade cell of a BCD counter. Holds a single digit 0..9,
//           steps it up (or down when BCD_CNT_DOWN_EN is defined) and
//           reports a carry/borrow on the step that rolls it over.
//
// Config  : BCD_CNT_DOWN_EN - when defined, up=0 counts down with a
//           borrow on 0->9. When undefined only up counting exists and a
//           step with up=0 is ignored.
//
// Ports   :
//   clk        in   1  clock
//   reset      in   1  synchronous, active-high; digit returns to 0
//   step       in   1  advance the digit this cycle
//   up         in   1  direction, 1 = up, 0 = down
//   load       in   1  overwrite the digit with load_digit (beats step)
//   load_digit in   4  value to load, already validated by the parent
//   digit      out  4  current digit, registered
//   co         out  1  carry/borrow out, combinational, high on the step
//                      that wraps 9->0 (up) or 0->9 (down)
// ---------------------------------------------------------------------------
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic       up,
    input  logic       load,
    input  bcd_digit_t load_digit,
    output bcd_digit_t digit,
    output logic       co
);

    bcd_digit_t digit_next;

    // Per-nibble decimal arithmetic: the rollover is detected on the
    // current digit and the next value is chosen directly, so the register
    // never holds a nibble above 9, not even for one cycle. The carry is
    // combinational so the next decade can step in the very same cycle.
    always_comb begin
        digit_next = digit;
        co         = 1'b0;
        if (step && up) begin
            if (digit == BCD_MAX) begin
                digit_next = BCD_MIN;
                co         = 1'b1;
            end else begin
                digit_next = digit + 4'd1;
            end
        end
`ifdef BCD_CNT_DOWN_EN
        else if (step && !up) begin
            if (digit == BCD_MIN) begin
                digit_next = BCD_MAX;
                co         = 1'b1;
            end else begin
                digit_next = digit - 4'd1;
            end
        end
`endif
    end

    // Digit register. Reset beats load, load beats the step result.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit <= BCD_MIN;
        end else if (load) begin
            digit <= load_digit;
        end else begin
            digit <= digit_next;
        end
    end

endmodule : bcd_digit

// File: rtl/bcd_count2.sv
// ---------------------------------------------------------------------------
// bcd_count2
//
// Purpose : Two-digit BCD counter 00..99 with a built-in prescaler that
//           turns the board clock into a slow step rate. Supports run/hold,
//           validated parallel load, and one-cycle tick/wrap/load_err
//           strobes. All outputs are registered.
//
// Config  : BCD_CNT_DOWN_EN - when defined the `up` port exists and up=0
//           counts down with a 00->99 wrap. When undefined the counter is
//           up-only and the `up` port is absent.
//
// Params  :
//   TICK_DIV  clock cycles per count step (>= 2)
//   TICK_W    prescaler width, derived from TICK_DIV
//
// Ports   :
//   CLOCK_50  in   1  system clock, the only clock
//   reset     in   1  synchronous, active-high
//   en        in   1  1 = run, 0 = hold prescaler and count
//   load      in   1  load load_val this cycle (honoured regardless of en)
//   load_val  in   8  BCD value to load; tens [7:4], ones [3:0]
//   up        in   1  direction, 1 = up (only with BCD_CNT_DOWN_EN)
//   bcd       out  8  current count; tens [7:4], ones [3:0]
//   tick      out  1  pulse in the cycle after each count step
//   wrap      out  1  pulse in the cycle after 99->00 or 00->99
//   load_err  out  1  pulse in the cycle after a rejected load
// ---------------------------------------------------------------------------
module bcd_count2
    import bcd_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
)
(
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] load_val,
`ifdef BCD_CNT_DOWN_EN
    input  logic       up,
`endif
    output logic [7:0] bcd,
    output logic       tick,
    output logic       wrap,
    output logic       load_err
);

    localparam int              TICK_W  = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] PC_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] pc;
    logic              count_up;
    logic              load_ok;
    logic              digit_load;
    logic              step_cycle;
    logic              ones_co;
    logic              tens_co;
    bcd_pair_t         count;

    // In the up-only build the direction is fixed, so the down path inside
    // the decade cells is never selected.
`ifdef BCD_CNT_DOWN_EN
    assign count_up = up;
`else
    assign count_up = 1'b1;
`endif

    // A load is only applied when both nibbles are legal digits; a bad
    // load leaves the count alone but still restarts the prescaler.
    assign load_ok    = bcd_valid(load_val[7:4]) && bcd_valid(load_val[3:0]);
    assign digit_load = load && load_ok;

    // A step needs the prescaler at its last count while running, and any
    // load (good or bad) in the same cycle swallows it.
    assign step_cycle = en && !load && (pc == PC_LAST);

    // Ones decade steps on every step cycle; its carry/borrow steps the
    // tens decade in the same cycle, and the tens carry/borrow is the
    // full-range wrap.
    bcd_digit u_ones (
        .clk        (CLOCK_50),
        .reset      (reset),
        .step       (step_cycle),
        .up         (count_up),
        .load       (digit_load),
        .load_digit (load_val[3:0]),
        .digit      (count.ones),
        .co         (ones_co)
    );

    bcd_digit u_tens (
        .clk        (CLOCK_50),
        .reset      (reset),
        .step       (ones_co),
        .up         (count_up),
        .load       (digit_load),
        .load_digit (load_val[7:4]),
        .digit      (count.tens),
        .co         (tens_co)
    );

    assign bcd = count;

    // Prescaler and strobe registers. Any load restarts the prescaler so
    // the next step lands a full TICK_DIV cycles later. With en low and no
    // load the prescaler holds, so a step cycle that loses en is simply
    // postponed rather than skipped to the next period.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pc       <= '0;
            tick     <= 1'b0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tick     <= step_cycle;
            wrap     <= tens_co;
            load_err <= load && !load_ok;
            if (load) begin
                pc <= '0;
            end else if (en) begin
                if (pc == PC_LAST) begin
                    pc <= '0;
                end else begin
                    pc <= pc + 1'b1;
                end
            end
        end
    end

endmodule : bcd_count2

// File: tb/tb_bcd_count2.sv
// ---------------------------------------------------------------------------
// tb_bcd_count2
//
// Purpose : Self-checking bench for bcd_count2 with TICK_DIV = 4. A
//           decimal reference model predicts the registered outputs for
//           every driven cycle and pushes them to a scoreboard queue; each
//           test task pops and compares after the clock edge.
//
// Config  : BCD_CNT_DOWN_EN - when defined the up port is connected and
//           the down-counting scenarios are included.
// ---------------------------------------------------------------------------
module tb_bcd_count2;

    localparam int TICK_DIV = 4;

    typedef struct packed {
        logic [7:0] bcd;
        logic       tick;
        logic       wrap;
        logic       err;
    } obs_t;

    logic       CLOCK_50;
    logic       reset;
    logic       en;
    logic       load;
    logic [7:0] load_val;
    logic       up_drv;
    logic [7:0] bcd;
    logic       tick;
    logic       wrap;
    logic       load_err;

    obs_t sb[$];
    int   checks;
    int   passes;
    int   mval;
    int   mpc;

    bcd_count2 #(.TICK_DIV(TICK_DIV)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .load_val (load_val),
`ifdef BCD_CNT_DOWN_EN
        .up       (up_drv),
`endif
        .bcd      (bcd),
        .tick     (tick),
        .wrap     (wrap),
        .load_err (load_err)
    );

    // Free-running board clock, 10 time units per period.
    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    function automatic obs_t observe();
        obs_t o;
        o.bcd  = bcd;
        o.tick = tick;
        o.wrap = wrap;
        o.err  = load_err;
        return o;
    endfunction

    // Drives one cycle of inputs, advances the decimal model (count kept
    // as an integer 0..99, not as nibbles), queues the expected outputs
    // and waits until just after the clock edge that registers them.
    task automatic applyStimulus(input logic r, input logic e, input logic l,
                                 input logic [7:0] lv, input logic u);
        obs_t exp;
        logic dir_up;
        int   old;
        dir_up = u;
`ifndef BCD_CNT_DOWN_EN
        dir_up = 1'b1;
`endif
        reset    = r;
        en       = e;
        load     = l;
        load_val = lv;
        up_drv   = u;
        exp      = '0;
        if (r) begin
            mval = 0;
            mpc  = 0;
        end else if (l) begin
            mpc = 0;
            if (int'(lv[7:4]) <= 9 && int'(lv[3:0]) <= 9)
                mval = int'(lv[7:4]) * 10 + int'(lv[3:0]);
            else
                exp.err = 1'b1;
        end else if (e) begin
            if (mpc == TICK_DIV - 1) begin
                mpc      = 0;
                old      = mval;
                exp.tick = 1'b1;
                if (dir_up) begin
                    mval     = (old + 1) % 100;
                    exp.wrap = (old == 99);
                end else begin
                    mval     = (old + 99) % 100;
                    exp.wrap = (old == 0);
                end
            end else begin
                mpc = mpc + 1;
            end
        end
        exp.bcd = {4'(mval / 10), 4'(mval % 10)};
        sb.push_back(exp);
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        got = observe();
        exp = sb.pop_front();
        checks++;
        if (got !== exp)
            $display("[TB] FAIL reset: got %h/%b/%b/%b expected %h/%b/%b/%b",
                     got.bcd, got.tick, got.wrap, got.err, exp.bcd, exp.tick, exp.wrap, exp.err);
        else passes++;
    endtask

    task automatic test_run();
        obs_t got, exp;
        int   ticks;
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
            got = observe();
            exp = sb.pop_front();
            if (i >= 4 && got.tick === 1'b1) ticks++;
            checks++;
            if (got !== exp)
                $display("[TB] FAIL run cycle %0d: got %h/%b/%b/%b expected %h/%b/%b/%b", i,
                         got.bcd, got.tick, got.wrap, got.err, exp.bcd, exp.tick, exp.wrap, exp.err);
            else passes++;
        end
        checks++;
        if (ticks !== 2)
            $display("[TB] FAIL tick_rate: got %0d ticks in 8 cycles, expected 2", ticks);
        else passes++;
    endtask

    // Loads a start value, then runs long enough for exactly one step.
    task automatic test_step_from(input string name, input logic [7:0] start,
                                  input logic u, input logic [7:0] want,
                                  input logic want_wrap);
        obs_t got, exp;
        applyStimulus(1'b0, 1'b1, 1'b1, start, u);
        for (int i = 0; i < TICK_DIV; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, u);
            got = observe();
            exp = sb.pop_front();
            if (i == 0) exp = sb.pop_front();
            checks++;
            if (got !== exp)
                $display("[TB] FAIL %s cycle %0d: got %h/%b/%b/%b expected %h/%b/%b/%b", name, i,
                         got.bcd, got.tick, got.wrap, got.err, exp.bcd, exp.tick, exp.wrap, exp.err);
            else passes++;
        end
        got = observe();
        checks++;
        if (got.bcd !== want || got.tick !== 1'b1 || got.wrap !== want_wrap)
            $display("[TB] FAIL %s_final: got bcd=%h tick=%b wrap=%b expected bcd=%h tick=1 wrap=%b",
                     name, got.bcd, got.tick, got.wrap, want, want_wrap);
        else passes++;
    endtask

    task automatic test_invalid_load();
        obs_t got, exp;
        logic [8:0] seq [6];
        // {load, load_val}: good load 42, bad load 3A, then four run cycles
        seq = '{9'h142, 9'h13A, 9'h000, 9'h000, 9'h000, 9'h000};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, seq[i][8], seq[i][7:0], 1'b1);
            got = observe();
            exp = sb.pop_front();
            checks++;
            if (got !== exp)
                $display("[TB] FAIL invalid_load cycle %0d: got %h/%b/%b/%b expected %h/%b/%b/%b", i,
                         got.bcd, got.tick, got.wrap, got.err, exp.bcd, exp.tick, exp.wrap, exp.err);
            else passes++;
        end
        checks++;
        if (got.bcd !== 8'h43 || got.tick !== 1'b1)
            $display("[TB] FAIL invalid_load_step: got bcd=%h tick=%b expected bcd=43 tick=1",
                     got.bcd, got.tick);
        else passes++;
    endtask

    // Parks the prescaler on its step value, holds for 10 cycles, then
    // resumes; the step must happen on the first resumed cycle.
    task automatic test_hold();
        obs_t got, exp;
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h27, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b0, (i < 3 || i >= 13), 1'b0, 8'h00, 1'b1);
            got = observe();
            exp = sb.pop_front();
            checks++;
            if (got !== exp)
                $display("[TB] FAIL hold cycle %0d: got %h/%b/%b/%b expected %h/%b/%b/%b", i,
                         got.bcd, got.tick, got.wrap, got.err, exp.bcd, exp.tick, exp.wrap, exp.err);
            else passes++;
        end
    endtask

    // Brings the prescaler to its step value, then loads on that cycle.
    task automatic test_load_on_step();
        obs_t got, exp;
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h10, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
            void'(sb.pop_front());
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h55, 1'b1);
        got = observe();
        exp = sb.pop_front();
        checks++;
        if (got !== exp || got.bcd !== 8'h55 || got.tick !== 1'b0)
            $display("[TB] FAIL load_on_step: got %h/%b/%b/%b expected 55/0/0/0",
                     got.bcd, got.tick, got.wrap, got.err);
        else passes++;
    endtask

    task automatic test_reset_with_load();
        obs_t got, exp;
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h77, 1'b1);
        got = observe();
        exp = sb.pop_front();
        checks++;
        if (got !== exp)
            $display("[TB] FAIL reset_with_load: got %h/%b/%b/%b expected %h/%b/%b/%b",
                     got.bcd, got.tick, got.wrap, got.err, exp.bcd, exp.tick, exp.wrap, exp.err);
        else passes++;
    endtask

    // Long mixed run: random en/up with occasional loads and resets.
    task automatic test_back_to_back();
        obs_t got, exp;
        logic r, e, l, u;
        logic [7:0] lv;
        for (int i = 0; i < 300; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            e  = ($urandom_range(0, 9) != 0);
            l  = ($urandom_range(0, 29) == 0);
            lv = 8'($urandom_range(0, 255));
            u  = ($urandom_range(0, 3) != 0);
            applyStimulus(r, e, l, lv, u);
            got = observe();
            exp = sb.pop_front();
            checks++;
            if (got !== exp)
                $display("[TB] FAIL back_to_back cycle %0d: got %h/%b/%b/%b expected %h/%b/%b/%b", i,
                         got.bcd, got.tick, got.wrap, got.err, exp.bcd, exp.tick, exp.wrap, exp.err);
            else passes++;
        end
    endtask

    initial begin
        checks   = 0;
        passes   = 0;
        mval     = 0;
        mpc      = 0;
        reset    = 1'b1;
        en       = 1'b0;
        load     = 1'b0;
        load_val = 8'h00;
        up_drv   = 1'b1;
        @(posedge CLOCK_50);
        #1;
        $display("[TB] starting bcd_count2 checks, TICK_DIV=%0d", TICK_DIV);
        test_reset();
        test_run();
        test_step_from("decade_carry", 8'h19, 1'b1, 8'h20, 1'b0);
        test_step_from("wrap_up", 8'h99, 1'b1, 8'h00, 1'b1);
        test_invalid_load();
        test_hold();
        test_load_on_step();
        test_reset_with_load();
`ifdef BCD_CNT_DOWN_EN
        test_step_from("down_borrow", 8'h10, 1'b0, 8'h09, 1'b0);
        test_step_from("wrap_down", 8'h00, 1'b0, 8'h99, 1'b1);
`endif
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_bcd_count2
